// File: rtl/prog_loader.sv
// Program loader: assembles a little-endian byte stream into 9-bit words,
// writes them into the instruction memory from address 0, and holds the
// core until the length header and XOR checksum have both been verified.
module prog_loader #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               imem_wr_en,
    output logic [PC_W-1:0]    imem_addr,
    output logic [INSTR_W-1:0] imem_wr_data,
    output logic               cpu_hold,
    output logic               done,
    output logic               err,
    output logic [PC_W:0]      words_loaded
);

    typedef enum logic [3:0] {
        IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_W_LO,
        S_W_HI,
        S_WRITE,
        S_CS_LO,
        S_CS_HI,
        DONE,
        ERR
    } state_t;

    state_t state;
    state_t next_state;

    logic [15:0]        len;
    logic [INSTR_W-1:0] csum;
    logic [7:0]         lo_byte;

    logic        accept;
    logic        start_ok;
    logic [15:0] len_full;
    logic        len_over;
    logic        more_words;
    logic        hi_byte_ok;
    logic        csum_ok;

    // Handshake and decision terms shared by the FSM and the datapath
    always_comb begin
        accept     = byte_valid & byte_ready;
        start_ok   = start && ((state == IDLE) || (state == DONE) || (state == ERR));
        len_full   = {byte_in, len[7:0]};
        len_over   = ({16'd0, len_full} > (32'd1 << PC_W));
        more_words = ((32'(words_loaded) + 32'd1) < {16'd0, len});
        hi_byte_ok = (byte_in[7:1] == 7'd0);
        csum_ok    = hi_byte_ok && ({byte_in[0], lo_byte} == csum);
    end

    // State register; reset takes priority over a simultaneous start
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        next_state = state;
        byte_ready = 1'b0;
        imem_wr_en = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = S_LEN_LO;
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) next_state = S_LEN_LO;
            end
            ERR: begin
                err = 1'b1;
                if (start) next_state = S_LEN_LO;
            end
            S_LEN_LO: begin
                byte_ready = 1'b1;
                if (accept) next_state = S_LEN_HI;
            end
            S_LEN_HI: begin
                byte_ready = 1'b1;
                if (accept) begin
                    if (len_over)              next_state = ERR;
                    else if (len_full == 16'd0) next_state = S_CS_LO;
                    else                        next_state = S_W_LO;
                end
            end
            S_W_LO: begin
                byte_ready = 1'b1;
                if (accept) next_state = S_W_HI;
            end
            S_W_HI: begin
                byte_ready = 1'b1;
                if (accept) next_state = hi_byte_ok ? S_WRITE : ERR;
            end
            S_WRITE: begin
                imem_wr_en = 1'b1;
                next_state = more_words ? S_W_LO : S_CS_LO;
            end
            S_CS_LO: begin
                byte_ready = 1'b1;
                if (accept) next_state = S_CS_HI;
            end
            S_CS_HI: begin
                byte_ready = 1'b1;
                if (accept) next_state = csum_ok ? DONE : ERR;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: length/low-byte latches, write word, checksum, address and count
    always_ff @(posedge clk) begin
        if (reset) begin
            len          <= '0;
            csum         <= '0;
            lo_byte      <= '0;
            imem_addr    <= '0;
            imem_wr_data <= '0;
            words_loaded <= '0;
        end else begin
            if (start_ok) begin
                csum         <= '0;
                words_loaded <= '0;
                imem_addr    <= '0;
            end
            if (accept) begin
                case (state)
                    S_LEN_LO: len[7:0] <= byte_in;
                    S_LEN_HI: len      <= len_full;
                    S_W_LO:   lo_byte  <= byte_in;
                    S_CS_LO:  lo_byte  <= byte_in;
                    S_W_HI: begin
                        if (hi_byte_ok) imem_wr_data <= {byte_in[0], lo_byte};
                    end
                    default: begin
                    end
                endcase
            end
            if (state == S_WRITE) begin
                csum         <= csum ^ imem_wr_data;
                words_loaded <= words_loaded + 1'b1;
                if (imem_addr != '1) imem_addr <= imem_addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: normal, bad checksum, zero
// length, malformed word, oversize header, back-pressure and reset cases.
module tb_prog_loader;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;

    logic               clk;
    logic               reset;
    logic               start;
    logic [7:0]         byte_in;
    logic               byte_valid;
    logic               byte_ready;
    logic               imem_wr_en;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_wr_data;
    logic               cpu_hold;
    logic               done;
    logic               err;
    logic [PC_W:0]      words_loaded;

    int n_asserts;
    int n_fails;

    logic [PC_W+INSTR_W-1:0] wq[$];

    prog_loader #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .imem_wr_en   (imem_wr_en),
        .imem_addr    (imem_addr),
        .imem_wr_data (imem_wr_data),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe as {addr, data}, sampled mid-cycle
    always @(negedge clk) begin
        if (imem_wr_en === 1'b1) wq.push_back({imem_addr, imem_wr_data});
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offer one byte and hold it until accepted; optional idle cycle first
    task automatic applyStimulus(input logic [7:0] b, input bit gap);
        bit got;
        if (gap) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_in    = b;
        byte_valid = 1'b1;
        got        = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (byte_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_asserts++;
        assert (got)
        else begin
            n_fails++;
            $error("[TB] FAIL accept_timeout observed=%0h expected=%0h", got, 1'b1);
        end
        if (got) begin
            @(posedge clk);
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic checkWrites(input string tag, input int n, input logic [8:0] d0,
                               input logic [8:0] d1, input logic [8:0] d2);
        logic [8:0] exp_d[3];
        exp_d[0] = d0;
        exp_d[1] = d1;
        exp_d[2] = d2;
        checkOutput({tag, "_nwrites"}, wq.size(), n);
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_write"}, (i < wq.size()) ? 32'(wq[i]) : 32'hdead,
                        {13'd0, 10'(i), exp_d[i]});
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_byte_ready"}, byte_ready, 0);
        checkOutput({tag, "_wr_en"}, imem_wr_en, 0);
        checkOutput({tag, "_addr"}, imem_addr, 0);
        checkOutput({tag, "_wr_data"}, imem_wr_data, 0);
        checkOutput({tag, "_cpu_hold"}, cpu_hold, 1);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_words"}, words_loaded, 0);
    endtask

    // Directed sequence of load scenarios
    initial begin
        n_asserts  = 0;
        n_fails    = 0;
        reset      = 1'b1;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkResetState("por");
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] reset mid-load");
        pulseStart();
        applyStimulus(8'h03, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h01, 0);
        checkOutput("midload_wr_en", imem_wr_en, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkResetState("midload_rst");
        checkWrites("midload", 1, 9'h1F0, 9'h000, 9'h000);
        wq.delete();

        $display("[TB] normal load with ignored start");
        pulseStart();
        checkOutput("start_ready", byte_ready, 1);
        applyStimulus(8'h03, 0);
        applyStimulus(8'h00, 0);
        pulseStart();
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h55, 0);
        checkOutput("normal_hold_mid", cpu_hold, 1);
        applyStimulus(8'h00, 0);
        checkOutput("normal_done", done, 1);
        checkOutput("normal_err", err, 0);
        checkOutput("normal_cpu_hold", cpu_hold, 0);
        checkOutput("normal_words", words_loaded, 3);
        checkOutput("normal_addr", imem_addr, 3);
        checkOutput("normal_ready_idle", byte_ready, 0);
        checkWrites("normal", 3, 9'h1F0, 9'h0A5, 9'h100);
        wq.delete();

        $display("[TB] bad checksum");
        pulseStart();
        checkOutput("restart_done_clr", done, 0);
        checkOutput("restart_hold", cpu_hold, 1);
        applyStimulus(8'h03, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h54, 0);
        applyStimulus(8'h00, 0);
        checkOutput("badcs_err", err, 1);
        checkOutput("badcs_done", done, 0);
        checkOutput("badcs_cpu_hold", cpu_hold, 1);
        checkWrites("badcs", 3, 9'h1F0, 9'h0A5, 9'h100);
        wq.delete();

        $display("[TB] zero length");
        pulseStart();
        checkOutput("zero_err_clr", err, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        checkOutput("zero_done", done, 1);
        checkOutput("zero_words", words_loaded, 0);
        checkOutput("zero_nwrites", wq.size(), 0);

        $display("[TB] reset and start together");
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        checkOutput("rststart_ready", byte_ready, 0);
        checkOutput("rststart_done", done, 0);
        checkOutput("rststart_hold", cpu_hold, 1);

        $display("[TB] malformed high byte");
        pulseStart();
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h12, 0);
        applyStimulus(8'h03, 0);
        checkOutput("malf_err", err, 1);
        checkOutput("malf_ready", byte_ready, 0);
        checkOutput("malf_wr_en", imem_wr_en, 0);
        @(negedge clk);
        checkOutput("malf_nwrites", wq.size(), 0);
        checkOutput("malf_words", words_loaded, 0);

        $display("[TB] oversize length");
        pulseStart();
        applyStimulus(8'h01, 0);
        applyStimulus(8'h04, 0);
        checkOutput("over_err", err, 1);
        checkOutput("over_ready", byte_ready, 0);
        checkOutput("over_hold", cpu_hold, 1);

        $display("[TB] back-pressure two-word load");
        pulseStart();
        applyStimulus(8'h02, 1);
        applyStimulus(8'h00, 1);
        applyStimulus(8'hFF, 1);
        applyStimulus(8'h00, 1);
        applyStimulus(8'h01, 1);
        applyStimulus(8'h01, 1);
        applyStimulus(8'hFE, 1);
        applyStimulus(8'h01, 1);
        checkOutput("bp_done", done, 1);
        checkOutput("bp_err", err, 0);
        checkOutput("bp_words", words_loaded, 2);
        checkWrites("bp", 2, 9'h0FF, 9'h101, 9'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction memory: receives a byte stream from the host/testbench link and assembles it into 9-bit machine words. Writes the words to imem at sequential addresses from 0. The control decoder then reads and decodes these words.
- Holds the core in hold while loading. Verifies a length header and an XOR checksum, then releases the core or flags an error.

Parameters:
- PC_W, 10, imem address width; max program length 2**PC_W words.
- INSTR_W, 9, machine word width; fixed at 9, upper byte carries bit 8.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  loader accepts the byte; transfer occurs when byte_valid & byte_ready.
- imem_wr_en  out  1  one-cycle write strobe.
- imem_addr  out  PC_W  write address.
- imem_wr_data  out  INSTR_W  word to write.
- cpu_hold  out  1  keeps the core (PC) held while 1.
- done  out  1  load succeeded; level, held until next start or reset.
- err  out  1  load failed; level, held until next start or reset.
- words_loaded  out  PC_W+1  count of words written in the current/last load.

Behaviour:
- Reset values (on reset, from any state, mid-load included):
  - State IDLE.
  - Outputs: byte_ready=0, imem_wr_en=0, imem_addr=0, imem_wr_data=0, cpu_hold=1, done=0, err=0, words_loaded=0.
  - Internal: len=0, csum=0.
- Stream format (little-endian): LEN_LO, LEN_HI, then per word {W_LO=instr[7:0], W_HI={7'b0,instr[8]}}, then CSUM_LO, CSUM_HI. csum is the 9-bit XOR of all words; CSUM_HI bits[7:1] must be 0.
- States and transitions:
  - IDLE/DONE/ERR: byte_ready=0. On start, go to S_LEN_LO; clear done, err, csum, words_loaded and imem_addr; set cpu_hold=1.
  - S_LEN_LO: on accept, latch len[7:0].
  - S_LEN_HI: on accept, form len (16 bits).
    - len > 2**PC_W → ERR.
    - len == 0 → S_CS_LO.
    - otherwise → S_W_LO.
  - S_W_LO: on accept, latch low byte → S_W_HI.
  - S_W_HI: on accept:
    - byte[7:1] != 0 → ERR, no write.
    - Otherwise, in the next cycle: imem_wr_en=1 for exactly one cycle, imem_wr_data={byte[0],lo}, imem_addr = current index. Also csum ^= word and words_loaded++.
    - Then go to S_W_LO if words_loaded+1 < len, else S_CS_LO.
  - S_CS_LO, S_CS_HI: accept the two checksum bytes.
    - Match → DONE: done=1, cpu_hold=0.
    - Mismatch, or CSUM_HI[7:1] != 0 → ERR: err=1, cpu_hold stays 1.
- Address increment: imem_addr increments the cycle after each write strobe. It never wraps, because length is checked up front.
- byte_ready:
  - 1 in all S_* receive states, except the single write cycle after a W_HI accept.
  - 0 in that write cycle, which gives at most 1 accepted byte per 2 cycles during words.
  - 0 in IDLE/DONE/ERR.
- Stalls: byte_valid low stalls indefinitely, with no timeout and no state change.
- byte_valid with byte_ready=0 is ignored. The sender must hold the byte.
- start while in an S_* state is ignored; only reset aborts a load.
- start asserted in the same cycle as reset: reset wins.
- done and err are never both 1.
- Latency: last CSUM_HI accept → done/err asserted on the next rising edge.

Test Plan:
- Reset mid-load: start, then send LEN=3 and one word, then pulse reset → all outputs at reset values, byte_ready=0. A new start followed by a full stream of 3 words loads cleanly from addr 0.
- Normal load, 3 words 9'h1F0, 9'h0A5, 9'h100 (bytes 03 00 F0 01 A5 00 00 01 55 00, csum 9'h055):
  - Strobes at addr 0,1,2 with those data.
  - done=1, cpu_hold=0, words_loaded=3.
- Bad checksum: same stream with CSUM_LO=0x54 → err=1, done=0, cpu_hold=1, three writes still occurred.
- Zero length: stream 00 00 00 00 → no imem_wr_en, done=1, words_loaded=0.
- Malformed high byte: W_HI=0x03 on word 0 → err=1 right after the accept, no write strobe, byte_ready=0.
- Oversize and back-pressure:
  - LEN = 2**PC_W+1 → err right after the LEN_HI accept.
  - Separately, byte_valid toggled every other cycle during a 2-word load → identical writes and done=1.
